// File: rtl/ternary_conv_accum_pkg.sv
// Shared constants and helpers for the ternary 3x3 conv accumulator.
// Weight code encodings and a width-parameterised signed saturator.
package ternary_pkg;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;

  // Clamp v into the signed range of a w-bit result.
  function automatic logic signed [63:0] sat_signed(
    input logic signed [63:0] v,
    input int unsigned        w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ternary_conv_accum_if.sv
// Window-in / activation-out handshake bundle.
// master drives beats and out_ready; slave is the accumulator.
interface ternary_conv_accum_if #(
  parameter int DATA_W  = 6,
  parameter int SCALE_W = 16,
  parameter int OUT_W   = 6
);
  logic                      in_valid;
  logic                      in_ready;
  logic [17:0]               w;
  logic [9*DATA_W-1:0]       x;
  logic signed [SCALE_W-1:0] r;
  logic signed [SCALE_W-1:0] b;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   data_out;
  logic                      out_last;

  modport master (
    output in_valid, w, x, r, b, out_ready,
    input  in_ready, out_valid, data_out, out_last
  );

  modport slave (
    input  in_valid, w, x, r, b, out_ready,
    output in_ready, out_valid, data_out, out_last
  );
endinterface

// File: rtl/ternary_conv_accum_postproc.sv
// Scale, floor-shift, bias and saturate of a finished accumulation.
// Purely combinational; feeds the output register.
module ternary_postproc
  import ternary_pkg::*;
#(
  parameter int ACC_W   = 13,
  parameter int SCALE_W = 16,
  parameter int SHIFT   = 3,
  parameter int OUT_W   = 6
) (
  input  logic signed [ACC_W-1:0]   acc,
  input  logic signed [SCALE_W-1:0] r,
  input  logic signed [SCALE_W-1:0] b,
  output logic signed [OUT_W-1:0]   y
);
  localparam int P_W = ACC_W + SCALE_W;

  logic signed [P_W-1:0] p;
  logic signed [P_W:0]   q;

  // Full-width product, arithmetic shift floors toward -inf.
  always_comb begin
    p = P_W'(acc) * P_W'(r);
    q = (P_W+1)'(p >>> SHIFT) + (P_W+1)'(b);
    y = OUT_W'(sat_signed(64'(q), OUT_W));
  end
endmodule

// File: rtl/ternary_conv_accum.sv
// Ternary 3x3 window dot product, per-position accumulation
// across channel groups, then scaled/saturated output.
module ternary_conv_accum
  import ternary_pkg::*;
#(
  parameter int DATA_W     = 6,
  parameter int INPUT_SIZE = 16,
  parameter int ADDR_BITS  = 4,
  parameter int CH_GROUPS  = 1,
  parameter int ACC_W      = 13,
  parameter int SCALE_W    = 16,
  parameter int SHIFT      = 3,
  parameter int OUT_W      = 6
) (
  input logic           clk,
  input logic           rst_n,
  ternary_conv_accum_if.slave bus
);
  localparam int TERM_W = DATA_W + 1;
  localparam int ROW_W  = DATA_W + 3;
  localparam int GRP_W  = (CH_GROUPS > 1) ? $clog2(CH_GROUPS) : 1;
  localparam logic [ADDR_BITS-1:0] POS_LAST = ADDR_BITS'(INPUT_SIZE - 1);
  localparam logic [GRP_W-1:0]     GRP_LAST = GRP_W'(CH_GROUPS - 1);

  logic adv;
  logic fire;
  logic [ADDR_BITS-1:0] pos_q, pos_d, pos1_q, pos2_q, pos3_q;
  logic [GRP_W-1:0]     grp_q, grp_d, grp1_q, grp2_q, grp3_q;
  logic v1_q, v2_q, v3_q;
  logic signed [TERM_W-1:0] term [9];
  logic signed [ROW_W-1:0]  row_d [3];
  logic signed [ROW_W-1:0]  row_q [3];
  logic signed [ACC_W-1:0]  win_d, win_q, acc_d, acc_q;
  logic signed [ACC_W-1:0]  lb_q [INPUT_SIZE];
  logic signed [OUT_W-1:0]  pp_y, dout_d, dout_q;
  logic ov_d, ov_q, ol_d, ol_q;

  assign adv           = !ov_q || bus.out_ready;
  assign fire          = bus.in_valid && adv;
  assign bus.in_ready  = adv;
  assign bus.out_valid = ov_q;
  assign bus.out_last  = ol_q;
  assign bus.data_out  = dout_q;

  // Position/group tags for the next accepted beat.
  always_comb begin
    pos_d = pos_q;
    grp_d = grp_q;
    if (fire) begin
      if (pos_q == POS_LAST) begin
        pos_d = '0;
        grp_d = (grp_q == GRP_LAST) ? '0 : grp_q + GRP_W'(1);
      end else begin
        pos_d = pos_q + ADDR_BITS'(1);
      end
    end
  end

  // Ternary terms and the three row sums.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      unique case (1'b1)
        (bus.w[2*i +: 2] == W_POS):
          term[i] = TERM_W'($signed(bus.x[i*DATA_W +: DATA_W]));
        (bus.w[2*i +: 2] == W_NEG):
          term[i] = -TERM_W'($signed(bus.x[i*DATA_W +: DATA_W]));
        default:
          term[i] = '0;
      endcase
    end
    for (int j = 0; j < 3; j++) begin
      row_d[j] = ROW_W'(term[3*j]) + ROW_W'(term[3*j+1])
               + ROW_W'(term[3*j+2]);
    end
  end

  // Window sum and line-buffer accumulate; group 0 starts fresh.
  always_comb begin
    win_d = ACC_W'(row_q[0]) + ACC_W'(row_q[1]) + ACC_W'(row_q[2]);
    if (grp2_q == '0) acc_d = win_q;
    else              acc_d = win_q + lb_q[pos2_q];
  end

  // Only the last group produces an output beat.
  always_comb begin
    ov_d   = v3_q && (grp3_q == GRP_LAST);
    ol_d   = ov_d && (pos3_q == POS_LAST);
    dout_d = ov_d ? pp_y : dout_q;
  end

  ternary_postproc #(
    .ACC_W  (ACC_W),
    .SCALE_W(SCALE_W),
    .SHIFT  (SHIFT),
    .OUT_W  (OUT_W)
  ) u_pp (
    .acc(acc_q),
    .r  (bus.r),
    .b  (bus.b),
    .y  (pp_y)
  );

  // Pipeline stages; everything advances together on adv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      grp_q  <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      pos1_q <= '0;
      pos2_q <= '0;
      pos3_q <= '0;
      grp1_q <= '0;
      grp2_q <= '0;
      grp3_q <= '0;
      for (int j = 0; j < 3; j++) row_q[j] <= '0;
      win_q  <= '0;
      acc_q  <= '0;
      ov_q   <= 1'b0;
      ol_q   <= 1'b0;
      dout_q <= '0;
    end else if (adv) begin
      pos_q  <= pos_d;
      grp_q  <= grp_d;
      v1_q   <= fire;
      pos1_q <= pos_q;
      grp1_q <= grp_q;
      for (int j = 0; j < 3; j++) row_q[j] <= row_d[j];
      v2_q   <= v1_q;
      pos2_q <= pos1_q;
      grp2_q <= grp1_q;
      win_q  <= win_d;
      v3_q   <= v2_q;
      pos3_q <= pos2_q;
      grp3_q <= grp2_q;
      acc_q  <= acc_d;
      ov_q   <= ov_d;
      ol_q   <= ol_d;
      dout_q <= dout_d;
    end
  end

  // Partial sums per position; contents before group 0 are don't-care.
  always_ff @(posedge clk) begin
    if (adv && v2_q) lb_q[pos2_q] <= acc_d;
  end
endmodule

// File: tb/tb_ternary_conv_accum.sv
// Scoreboard bench for ternary_conv_accum across four configs.
// Stimulus pushes expectations; per-DUT monitors pop and compare.
module tb_ternary_conv_accum;
  localparam int DW = 6;
  localparam int XW = 9 * DW;
  localparam logic [17:0] WP = 18'h15555;
  localparam logic [17:0] WN = 18'h3FFFF;

  typedef struct {
    logic signed [5:0] d;
    logic              l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic [17:0]          w = '0;
  logic [XW-1:0]        x = '0;
  logic signed [15:0]   r = 16'sd1;
  logic signed [15:0]   b = 16'sd0;
  logic                 out_ready = 1'b1;
  int                   sel = 0;

  logic              rdy_a [4];
  logic              ov_a  [4];
  logic              ol_a  [4];
  logic signed [5:0] do_a  [4];

  exp_t q [4][$];
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;
  int first_out [4] = '{-1, -1, -1, -1};

  always @(posedge clk) cyc++;

  ternary_conv_accum_if #(.DATA_W(6), .SCALE_W(16), .OUT_W(6)) bus [4] ();

  task automatic chk_out(int k, logic signed [5:0] d, logic l);
    exp_t e;
    checks++;
    if (q[k].size() == 0) begin
      fails++;
      $display("FAIL out%0d unexpected beat data=%0d last=%0d", k, d, l);
    end else begin
      e = q[k].pop_front();
      if (d !== e.d || l !== e.l) begin
        fails++;
        $display("FAIL out%0d data=%0d last=%0d expected data=%0d last=%0d",
                 k, d, l, e.d, e.l);
      end
    end
  endtask

  for (genvar k = 0; k < 4; k++) begin : g
    localparam int CH = (k == 1) ? 2 : 1;
    localparam int SH = (k == 2) ? 3 : ((k == 3) ? 1 : 0);
    assign bus[k].in_valid  = in_valid && (sel == k);
    assign bus[k].w         = w;
    assign bus[k].x         = x;
    assign bus[k].r         = r;
    assign bus[k].b         = b;
    assign bus[k].out_ready = out_ready;
    assign rdy_a[k] = bus[k].in_ready;
    assign ov_a[k]  = bus[k].out_valid;
    assign ol_a[k]  = bus[k].out_last;
    assign do_a[k]  = bus[k].data_out;

    ternary_conv_accum #(
      .DATA_W(6), .INPUT_SIZE(4), .ADDR_BITS(2), .CH_GROUPS(CH),
      .ACC_W(13), .SCALE_W(16), .SHIFT(SH), .OUT_W(6)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus[k])
    );

    always @(negedge clk) begin
      #2;
      if (rst_n && ov_a[k]) begin
        if (first_out[k] < 0) first_out[k] = cyc;
        if (out_ready) chk_out(k, do_a[k], ol_a[k]);
      end
    end
  end

  task automatic cmp(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [XW-1:0] xall(int v);
    logic [XW-1:0] t;
    for (int i = 0; i < 9; i++) t[i*DW +: DW] = DW'(v);
    return t;
  endfunction

  function automatic logic [XW-1:0] xset(logic [XW-1:0] base, int i, int v);
    logic [XW-1:0] t;
    t = base;
    t[i*DW +: DW] = DW'(v);
    return t;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(int k, logic [17:0] wv, logic [XW-1:0] xv,
                      bit has, int ed, bit el);
    int n;
    n = 0;
    sel = k;
    w = wv;
    x = xv;
    in_valid = 1'b1;
    #1;
    while (!rdy_a[k] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rdy_a[k]) begin
      checks++;
      fails++;
      $display("FAIL send%0d in_ready timeout", k);
    end else begin
      last_acc = cyc;
      if (has) q[k].push_back('{d: 6'(ed), l: el});
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_b(int n_groups, bit check_g0);
    for (int i = 0; i < 4; i++) send(1, WP, xall(1), 0, 0, 0);
    if (check_g0) begin
      idle(5);
      cmp("g0_no_out", ov_a[1], 0);
    end
    for (int g = 1; g < n_groups; g++)
      for (int i = 0; i < 4; i++) send(1, WP, xall(1), 1, 18, i == 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int t0;
    int nw;
    repeat (3) @(negedge clk);
    #1;
    cmp("rst_out_valid", ov_a[0], 0);
    cmp("rst_in_ready", rdy_a[0], 1);
    cmp("rst_data_out", do_a[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic sum and latency
    t0 = 0;
    for (int i = 0; i < 4; i++) begin
      send(0, WP, xall(1), 1, 9, i == 3);
      if (i == 0) t0 = last_acc;
    end
    idle(8);
    cmp("latency", first_out[0] - t0, 4);

    // mixed weight codes
    send(0, 18'h22223, xall(5), 1, -5, 0);
    send(0, WN, xall(2), 1, -18, 0);
    send(0, WP, xall(-1), 1, -9, 0);
    send(0, 18'h2AAAD, xset(xset(xall(7), 0, 10), 1, 4), 1, 6, 1);
    idle(8);

    // scale, shift 3, bias
    r = 16'sd10;
    b = -16'sd2;
    send(2, WP, xall(1), 1, 9, 0);
    send(2, WN, xall(1), 1, -14, 0);
    send(2, 18'h00001, xset(xall(0), 0, 4), 1, 3, 0);
    send(2, 18'h00001, xset(xall(0), 0, 1), 1, -1, 1);
    idle(8);
    r = 16'sd1;
    b = 16'sd0;

    // shift 1 floor and saturation
    send(3, 18'h00003, xset(xall(0), 0, 5), 1, -3, 0);
    send(3, 18'h00001, xset(xall(0), 0, 5), 1, 2, 0);
    send(3, 18'h00003, xset(xall(0), 0, 1), 1, -1, 0);
    send(3, WP, xall(31), 1, 31, 1);
    idle(8);

    // two channel groups, two frames
    frame_b(2, 1);
    frame_b(2, 0);
    idle(8);

    // saturation at shift 0
    send(0, WP, xall(31), 1, 31, 0);
    send(0, WN, xall(31), 1, -32, 0);
    send(0, WP, xall(31), 1, 31, 0);
    send(0, WN, xall(31), 1, -32, 1);
    idle(8);

    // backpressure
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(0, 18'h00001, xset(xall(0), 0, i + 1), 1, i + 1, i == 3);
        in_valid = 1'b0;
      end
      begin
        nw = 0;
        @(negedge clk);
        while (!ov_a[0] && nw < 20) begin
          @(negedge clk);
          nw++;
        end
        cmp("bp_wait_valid", ov_a[0], 1);
        out_ready = 1'b0;
        repeat (3) begin
          #1;
          cmp("bp_in_ready", rdy_a[0], 0);
          cmp("bp_data_hold", do_a[0], 1);
          cmp("bp_valid_hold", ov_a[0], 1);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    idle(10);

    // reset mid-frame
    send(1, WP, xall(1), 0, 0, 0);
    send(1, WP, xall(1), 0, 0, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    cmp("mid_rst_valid", ov_a[1], 0);
    cmp("mid_rst_data", do_a[1], 0);
    cmp("mid_rst_last", ol_a[1], 0);
    cmp("mid_rst_ready", rdy_a[1], 1);
    cmp("mid_rst_data_a", do_a[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame_b(2, 0);
    idle(10);

    for (int k = 0; k < 4; k++)
      cmp($sformatf("drain%0d", k), q[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/ternary_conv_accum.md
# ternary_conv_accum

Parametrised ternary-weight 3×3 convolution accumulator. It replaces the fixed 6-bit, single-group, binary-weight adder. Each accepted beat is one 3×3 activation window for one input-channel group. The block forms the signed ternary dot product and accumulates it per output position in an internal line buffer across `CH_GROUPS` groups. On the last group it applies scale, arithmetic shift, bias and saturation, then emits one activation per position over a valid/ready handshake.

## Interface
- `DATA_W`, 6: signed activation width.
- `INPUT_SIZE`, 16: output positions per line, i.e. line-buffer depth; must be ≥2.
- `ADDR_BITS`, 4: line-buffer address width; must be ≥ clog2(`INPUT_SIZE`).
- `CH_GROUPS`, 1: channel groups accumulated per position (INPUT_CHANNEL/TI).
- `ACC_W`, 13: accumulator width; must be ≥ `DATA_W`+4+clog2(`CH_GROUPS`).
- `SCALE_W`, 16: signed width of `r` and `b`.
- `SHIFT`, 3: arithmetic right shift applied after the multiply.
- `OUT_W`, 6: signed output width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: window beat valid.
- `in_ready` out 1: block can accept a beat.
- `w` in 18: nine 2-bit ternary codes, w11 in bits [1:0] through w33 in bits [17:16]. 01 = +1, 11 = −1, 00 and 10 = 0.
- `x` in 9·`DATA_W`: nine signed activations, x11 in the LSBs, same order as `w`.
- `r` in `SCALE_W`: signed scale. Sampled when the last-group beat enters post-processing.
- `b` in `SCALE_W`: signed bias. Sampled in the same cycle as `r`.
- `out_valid` out 1: `data_out` valid.
- `out_ready` in 1: downstream accepts.
- `data_out` out `OUT_W`: saturated result.
- `out_last` out 1: qualifies the beat for position `INPUT_SIZE`−1, i.e. end of line.

## Operation
- Advance enable: `adv = !out_valid | out_ready`. `in_ready = adv`. Every pipeline register and valid bit updates only when `adv` is high.
- A beat is accepted when `in_valid & in_ready`.
- Each accepted beat is tagged with position `pos` and group `grp`.
  - `pos` counts 0..`INPUT_SIZE`−1 and wraps to 0.
  - `grp` increments when `pos` wraps, and wraps 0..`CH_GROUPS`−1.
  - Tags travel with the data.
- S1 (registered): each term is +x, −x or 0, width `DATA_W`+1. Three row sums, width `DATA_W`+3.
- S2 (registered): window sum of the three rows, sign-extended to `ACC_W`.
- S3 (registered):
  - `acc = (grp==0 ? 0 : lb[pos]) + window`. Two's-complement wrap at `ACC_W`.
  - `lb[pos] <= acc` is written in the same cycle.
  - The line buffer is never read when grp==0, so stale contents are harmless.
- S4 (registered, last group only):
  - `p = acc*r`, full width `ACC_W`+`SCALE_W`.
  - `q = (p >>> SHIFT) + b`. The shift floors toward −∞.
  - Saturate `q` to [−2^(`OUT_W`−1), 2^(`OUT_W`−1)−1].
  - `out_valid` rises only for last-group beats. Non-last groups produce no output.
- While `out_valid & !out_ready`: `data_out` and `out_last` hold stable and no beat is accepted.

## Timing
- Latency from acceptance to `out_valid`: 4 cycles with no stall. Throughput is 1 beat per cycle.
- Reset (asynchronous) clears the following:
  - `out_valid`, `out_last`, `data_out` to 0.
  - All stage valid bits.
  - `pos` and `grp` to 0.
- `in_ready` is 1 while in reset. `lb` is not reset.
- Reset mid-frame discards every in-flight beat. The next accepted beat is pos 0, grp 0.
- There is no read/write hazard: the same `lb` address is revisited at least `INPUT_SIZE` ≥ 2 accepted beats later.
- When a pos wrap and a grp wrap coincide, both counters return to 0 in the same cycle.

## Structure
- `ternary_pkg`: weight code constants `W_ZERO`, `W_POS`, `W_NEG`, and a `sat_signed` function parameterised by width.
- Sub-module `ternary_postproc`: combinational multiply, shift, bias and saturate between S3 and the S4 register. Parameters are `ACC_W`, `SCALE_W`, `SHIFT`, `OUT_W`.
- The top level holds the S1–S3 pipeline, the `lb` array, the counters and the handshake.

## Test plan
Unless stated otherwise, tests use `INPUT_SIZE`=4, `CH_GROUPS`=1, r=1, `SHIFT`=0, b=0.
- Single group, all w=01, all x=1, 4 beats: `data_out`=9 on every beat, first output 4 cycles after first acceptance, `out_last` on the 4th beat.
- Mixed weights, w11=11 (−1), other codes 00 and 10 (zero), x11=5: `data_out`=−5.
- Scale and bias: acc=9, r=10, `SHIFT`=3, b=−2 gives 9. acc=−5, r=1, `SHIFT`=1 gives −3 (floor).
- `CH_GROUPS`=2, all w=01, x=1 in both groups:
  - No `out_valid` during group 0.
  - Group 1 gives 18 on each position.
  - A second frame also gives 18, confirming the grp==0 overwrite.
- Saturation: all x=31. All w=01 gives 279, so `data_out`=31. All w=11 gives −279, so `data_out`=−32.
- Backpressure and reset:
  - Hold `out_ready`=0 for 3 cycles: `in_ready`=0, `data_out` stable, no loss or reorder.
  - Pulse `rst_n` low after 2 beats of group 0 of a `CH_GROUPS`=2 frame: all outputs 0.
  - The next full frame gives correct values.
